// File: rtl/raster_sample_feeder_pkg.sv
// Shared raster write-path definitions: handshake state encoding and default sample width.
package raster_sample_feeder_pkg;

    localparam int unsigned RASTER_DAT_WID = 24;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCommit  = 2'd1,
        StRelease = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/raster_sample_fifo.sv
// Synchronous sample FIFO: registered write, first-word-fall-through head, occupancy count.
module raster_sample_fifo #(
    parameter int unsigned DAT_WID   = 24,
    parameter int unsigned DEPTH_WID = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic [DAT_WID-1:0]   push_data_i,
    input  logic                 pop_i,
    output logic [DAT_WID-1:0]   head_o,
    output logic [DEPTH_WID:0]   fill_o
);

    localparam int unsigned Depth = 1 << DEPTH_WID;

    logic [DAT_WID-1:0]   mem_q [Depth];
    logic [DEPTH_WID-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WID-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_WID:0]   fill_q, fill_d;

    // Callers only assert push when there is room (or a same-edge pop frees one).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + DEPTH_WID'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + DEPTH_WID'(1);
            unique case ({push_i, pop_i})
                2'b10:   fill_d = fill_q + (DEPTH_WID + 1)'(1);
                2'b01:   fill_d = fill_q - (DEPTH_WID + 1)'(1);
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o = mem_q[rd_ptr_q];
    assign fill_o = fill_q;

endmodule

// File: rtl/raster_sample_feeder.sv
// Buffers strobed raster samples and hands them one at a time to the RAM shim over a
// level commit/finished handshake, counting committed and dropped samples.
module raster_sample_feeder
    import raster_sample_feeder_pkg::*;
#(
    parameter int unsigned DAT_WID   = RASTER_DAT_WID,
    parameter int unsigned DEPTH_WID = 4,
    parameter int unsigned CNT_WID   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DAT_WID-1:0]   in_data_i,
    input  logic                 in_valid_i,
    input  logic                 clear_i,
    output logic [DAT_WID-1:0]   data_o,
    output logic                 commit_o,
    input  logic                 finished_i,
    output logic [DEPTH_WID:0]   fill_o,
    output logic [CNT_WID-1:0]   sample_cnt_o,
    output logic [CNT_WID-1:0]   overflow_cnt_o,
    output logic                 busy_o
);

    localparam logic [DEPTH_WID:0] FillFull = {1'b1, {DEPTH_WID{1'b0}}};

    feeder_state_e      state_q, state_d;
    logic               commit_q, commit_d;
    logic [DAT_WID-1:0] data_q, data_d;
    logic [CNT_WID-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_WID-1:0] overflow_cnt_q, overflow_cnt_d;

    logic [DAT_WID-1:0]   head;
    logic [DEPTH_WID:0]   fill;
    logic                 full, pop, push, drop, done;

    assign full = (fill == FillFull);
    assign pop  = (state_q == StIdle) && (fill != '0) && !finished_i && !clear_i;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign push = in_valid_i && !clear_i && (!full || pop);
    assign drop = in_valid_i && !clear_i && full && !pop;

    raster_sample_fifo #(
        .DAT_WID   (DAT_WID),
        .DEPTH_WID (DEPTH_WID)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .push_i      (push),
        .push_data_i (in_data_i),
        .pop_i       (pop),
        .head_o      (head),
        .fill_o      (fill)
    );

    always_comb begin
        state_d  = state_q;
        commit_d = commit_q;
        data_d   = data_q;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d  = StCommit;
                    commit_d = 1'b1;
                    data_d   = head;
                end
            end
            StCommit: begin
                if (finished_i) begin
                    state_d  = StRelease;
                    commit_d = 1'b0;
                    done     = 1'b1;
                end
            end
            StRelease: begin
                if (!finished_i) state_d = StIdle;
            end
            default: begin
                state_d  = StIdle;
                commit_d = 1'b0;
            end
        endcase
    end

    // An in-flight handshake still counts when it completes on the clearing edge.
    always_comb begin
        sample_cnt_d   = sample_cnt_q + CNT_WID'(done);
        overflow_cnt_d = overflow_cnt_q;
        if (drop && (overflow_cnt_q != '1)) overflow_cnt_d = overflow_cnt_q + CNT_WID'(1);
        if (clear_i) begin
            sample_cnt_d   = CNT_WID'(done);
            overflow_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            commit_q       <= 1'b0;
            data_q         <= '0;
            sample_cnt_q   <= '0;
            overflow_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            commit_q       <= commit_d;
            data_q         <= data_d;
            sample_cnt_q   <= sample_cnt_d;
            overflow_cnt_q <= overflow_cnt_d;
        end
    end

    assign data_o         = data_q;
    assign commit_o       = commit_q;
    assign fill_o         = fill;
    assign sample_cnt_o   = sample_cnt_q;
    assign overflow_cnt_o = overflow_cnt_q;
    assign busy_o         = (state_q != StIdle) || (fill != '0);

endmodule

// File: tb/tb_raster_sample_feeder.sv
// Randomized self-checking bench for raster_sample_feeder against a queue-based behavioural model.
module tb_raster_sample_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        finished = 1'b0;
    logic [23:0] data;
    logic        commit;
    logic [4:0]  fill;
    logic [15:0] sample_cnt;
    logic [15:0] overflow_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    raster_sample_feeder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_data_i      (in_data),
        .in_valid_i     (in_valid),
        .clear_i        (clear),
        .data_o         (data),
        .commit_o       (commit),
        .finished_i     (finished),
        .fill_o         (fill),
        .sample_cnt_o   (sample_cnt),
        .overflow_cnt_o (overflow_cnt),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: the FIFO is a queue, the handshake a phase number
    // (0 waiting, 1 commit raised, 2 waiting for finished to drop).
    logic [23:0] m_q[$];
    int          m_phase;
    logic        m_commit;
    logic [23:0] m_data;
    logic [15:0] m_scnt;
    logic [15:0] m_ovf;

    // Shim model and output capture.
    bit          shim_auto = 0;
    int          shim_lat = 4;
    int          shim_cnt = 0;
    logic [23:0] dut_out[$];
    logic        prev_commit = 1'b0;

    function automatic logic [62:0] model_vec();
        logic busy_m;
        busy_m = (m_phase != 0) || (m_q.size() != 0);
        return {m_commit, m_data, 5'(m_q.size()), m_scnt, m_ovf, busy_m};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_phase  = 0;
        m_commit = 1'b0;
        m_data   = '0;
        m_scnt   = '0;
        m_ovf    = '0;
    endtask

    task automatic model_edge();
        bit go, done;
        if (rst) begin
            model_reset();
            return;
        end
        go   = (m_phase == 0) && (m_q.size() != 0) && !finished && !clear;
        done = (m_phase == 1) && finished;
        if (clear) begin
            m_q.delete();
            m_ovf  = '0;
            m_scnt = done ? 16'd1 : 16'd0;
        end else begin
            if (go) m_data = m_q.pop_front();
            if (in_valid) begin
                if (m_q.size() < 16) m_q.push_back(in_data);
                else if (m_ovf != 16'hffff) m_ovf = m_ovf + 16'd1;
            end
            if (done) m_scnt = m_scnt + 16'd1;
        end
        case (m_phase)
            0: if (go) begin m_phase = 1; m_commit = 1'b1; end
            1: if (finished) begin m_phase = 2; m_commit = 1'b0; end
            default: if (!finished) m_phase = 0;
        endcase
    endtask

    // Advance one clock: model takes the same inputs the DUT samples at this edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (commit && !prev_commit) dut_out.push_back(data);
        prev_commit = commit;
        if (shim_auto) begin
            if (m_commit) begin
                shim_cnt++;
                if (shim_cnt >= shim_lat) finished = 1'b1;
            end else begin
                finished = 1'b0;
                shim_cnt = 0;
            end
        end
    endtask

    task automatic strobe(input logic [23:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({commit, data, fill, sample_cnt, overflow_cnt, busy} !== 63'd0) begin
            errors++;
            $display("FAIL reset_state: got commit=%b data=%h fill=%0d scnt=%0d ovf=%0d busy=%b want all zero",
                     commit, data, fill, sample_cnt, overflow_cnt, busy);
        end
    endtask

    task automatic test_single();
        bit ok;
        dut_out.delete();
        shim_auto = 1;
        shim_lat  = 4;
        strobe(24'h800123);
        checks++;
        if (fill !== 5'd1 || commit !== 1'b0) begin
            errors++;
            $display("FAIL single_strobe_fill: got fill=%0d commit=%b want fill=1 commit=0", fill, commit);
        end
        step();
        checks++;
        if (commit !== 1'b1 || data !== 24'h800123) begin
            errors++;
            $display("FAIL single_commit_rise: got commit=%b data=%h want 1 800123", commit, data);
        end
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if ({commit, data, fill, sample_cnt, overflow_cnt, busy} !== model_vec()) begin
                errors++;
                $display("FAIL single_cycle: got %h want %h",
                         {commit, data, fill, sample_cnt, overflow_cnt, busy}, model_vec());
            end
            if (!busy && !finished) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok || sample_cnt !== 16'd1 || dut_out.size() != 1) begin
            errors++;
            $display("FAIL single_complete: got done=%0d scnt=%0d commits=%0d want 1 1 1",
                     ok, sample_cnt, dut_out.size());
        end
    endtask

    task automatic test_overflow();
        logic [23:0] sent[$];
        logic [23:0] v;
        bit ok;
        shim_auto = 0;
        finished  = 1'b0;
        do_clear();
        dut_out.delete();
        for (int i = 0; i < 19; i++) begin
            v = 24'($urandom);
            sent.push_back(v);
            strobe(v);
        end
        checks++;
        if (fill !== 5'd16 || overflow_cnt !== 16'd2 || commit !== 1'b1) begin
            errors++;
            $display("FAIL overflow_counts: got fill=%0d ovf=%0d commit=%b want 16 2 1",
                     fill, overflow_cnt, commit);
        end
        shim_auto = 1;
        shim_lat  = $urandom_range(0, 3);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            checks++;
            if ({commit, data, fill, sample_cnt, overflow_cnt, busy} !== model_vec()) begin
                errors++;
                $display("FAIL overflow_drain_cycle: got %h want %h",
                         {commit, data, fill, sample_cnt, overflow_cnt, busy}, model_vec());
            end
            if (!busy && !finished) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok || dut_out.size() != 17) begin
            errors++;
            $display("FAIL overflow_drain: got drained=%0d commits=%0d want 1 17", ok, dut_out.size());
        end
        for (int i = 0; i < 17 && i < dut_out.size(); i++) begin
            checks++;
            if (dut_out[i] !== sent[i]) begin
                errors++;
                $display("FAIL overflow_order[%0d]: got %h want %h", i, dut_out[i], sent[i]);
            end
        end
    endtask

    task automatic test_full_push_pop();
        logic [23:0] last;
        bit ok;
        shim_auto = 0;
        finished  = 1'b1;
        do_clear();
        step();
        dut_out.delete();
        for (int i = 0; i < 16; i++) strobe(24'($urandom));
        last     = 24'h5a5a5a;
        finished = 1'b0;
        strobe(last);
        checks++;
        if (fill !== 5'd16 || overflow_cnt !== 16'd0 || commit !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: got fill=%0d ovf=%0d commit=%b want 16 0 1",
                     fill, overflow_cnt, commit);
        end
        shim_auto = 1;
        shim_lat  = 1;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!busy && !finished) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok || dut_out.size() != 17 || dut_out[dut_out.size()-1] !== last) begin
            errors++;
            $display("FAIL full_push_pop_last: got drained=%0d commits=%0d last=%h want 1 17 %h",
                     ok, dut_out.size(), (dut_out.size() != 0) ? dut_out[dut_out.size()-1] : 24'h0, last);
        end
    endtask

    task automatic test_clear_in_commit();
        shim_auto = 0;
        finished  = 1'b0;
        do_clear();
        dut_out.delete();
        for (int i = 0; i < 6; i++) strobe(24'($urandom));
        checks++;
        if (fill !== 5'd5 || commit !== 1'b1) begin
            errors++;
            $display("FAIL clear_setup: got fill=%0d commit=%b want 5 1", fill, commit);
        end
        do_clear();
        checks++;
        if (fill !== 5'd0 || overflow_cnt !== 16'd0 || sample_cnt !== 16'd0 || commit !== 1'b1) begin
            errors++;
            $display("FAIL clear_effect: got fill=%0d ovf=%0d scnt=%0d commit=%b want 0 0 0 1",
                     fill, overflow_cnt, sample_cnt, commit);
        end
        shim_auto = 1;
        shim_lat  = 2;
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (sample_cnt !== 16'd1 || commit !== 1'b0 || busy !== 1'b0 || dut_out.size() != 1) begin
            errors++;
            $display("FAIL clear_complete: got scnt=%0d commit=%b busy=%b commits=%0d want 1 0 0 1",
                     sample_cnt, commit, busy, dut_out.size());
        end
    endtask

    task automatic test_reset_mid_handshake();
        shim_auto = 0;
        finished  = 1'b0;
        strobe(24'h0abcde);
        step();
        finished = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (commit !== 1'b0 || sample_cnt !== 16'd0 || overflow_cnt !== 16'd0 || fill !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: got commit=%b scnt=%0d ovf=%0d fill=%0d want all zero",
                     commit, sample_cnt, overflow_cnt, fill);
        end
        step();
        rst = 1'b0;
        prev_commit = commit;
        strobe(24'h123456);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (commit !== 1'b0 || fill !== 5'd1) begin
                errors++;
                $display("FAIL reset_wait_finished: got commit=%b fill=%0d want 0 1", commit, fill);
            end
        end
        finished = 1'b0;
        step();
        checks++;
        if (commit !== 1'b1 || data !== 24'h123456) begin
            errors++;
            $display("FAIL reset_recommit: got commit=%b data=%h want 1 123456", commit, data);
        end
        shim_auto = 1;
        shim_lat  = 1;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_finished_held();
        shim_auto = 0;
        finished  = 1'b0;
        do_clear();
        dut_out.delete();
        strobe(24'h111111);
        step();
        finished = 1'b1;
        strobe(24'h222222);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (commit !== 1'b0 || fill !== 5'd1) begin
                errors++;
                $display("FAIL finished_held[%0d]: got commit=%b fill=%0d want 0 1", i, commit, fill);
            end
            step();
        end
        finished = 1'b0;
        step();
        step();
        checks++;
        if (commit !== 1'b1 || data !== 24'h222222 || dut_out.size() != 2 || sample_cnt !== 16'd1) begin
            errors++;
            $display("FAIL finished_release: got commit=%b data=%h commits=%0d scnt=%0d want 1 222222 2 1",
                     commit, data, dut_out.size(), sample_cnt);
        end
        shim_auto = 1;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_random();
        shim_auto = 1;
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 24'($urandom);
            clear    = ($urandom_range(0, 199) == 0);
            if (!m_commit) shim_lat = $urandom_range(0, 5);
            step();
            checks++;
            if ({commit, data, fill, sample_cnt, overflow_cnt, busy} !== model_vec()) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h want %h", i,
                         {commit, data, fill, sample_cnt, overflow_cnt, busy}, model_vec());
            end
        end
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_clear_in_commit();
        test_reset_mid_handshake();
        test_finished_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
